// File: rtl/potential_decay_array.sv
// potential_decay_array: per-neuron FP32 membrane potentials with LIF decay scanned
// on each timestep start and streamed out over a valid/ready handshake.
module potential_decay_array #(
  parameter int NUM_NEURONS = 32,
  parameter int ADDR_W = 5,
  parameter logic [31:0] INIT_POTENTIAL = 32'h41DED852,
  parameter logic [3:0] INIT_RATE = 4'b0001
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              init_en,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [3:0]        init_rate,
  input  logic [31:0]       init_potential,
  input  logic              pot_wr_en,
  input  logic [ADDR_W-1:0] pot_wr_addr,
  input  logic [31:0]       pot_wr_data,
  input  logic              decay_start,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_potential,
  output logic              done,
  output logic              wr_collision
);
  typedef enum logic [1:0] {IDLE, FETCH, APPLY, FIN} state_t;
  state_t state;
  logic [31:0] pot [NUM_NEURONS];
  logic [3:0] rate [NUM_NEURONS];
  logic [ADDR_W-1:0] idx;
  logic [31:0] cur, dec;
  logic [3:0] r;
  logic [7:0] e, sh;
  logic [24:0] t;
  // t holds 3*{1,m} pre-shifted by one: t[24] is the carry into bit 25 of the product
  always_comb begin
    cur = pot[idx];
    r = rate[idx];
    e = cur[30:23];
    t = 25'((26'd3 * {2'b00, 1'b1, cur[22:0]}) >> 1);
    sh = r == 4'b0010 ? 8'd1 : r == 4'b0100 ? 8'd2 : r == 4'b1000 ? 8'd3 : 8'd0;
    dec = e == 8'hff ? cur :
          e == 8'h00 ? {cur[31], 31'b0} :
          r == 4'b0011 ? (t[24] ? {cur[31], e, t[23:1]} :
                          e == 8'd1 ? {cur[31], 31'b0} : {cur[31], e - 8'd1, t[22:0]}) :
          sh == 8'd0 ? cur :
          e <= sh ? {cur[31], 31'b0} : {cur[31], e - sh, cur[22:0]};
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        pot[i] <= INIT_POTENTIAL;
        rate[i] <= INIT_RATE;
      end
      state <= IDLE;
      idx <= '0;
      busy <= 1'b0;
      out_valid <= 1'b0;
      out_addr <= '0;
      out_potential <= '0;
      done <= 1'b0;
      wr_collision <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (pot_wr_en && !(init_en && init_addr == pot_wr_addr)) pot[pot_wr_addr] <= pot_wr_data;
        if (init_en) begin
          pot[init_addr] <= init_potential;
          rate[init_addr] <= init_rate;
        end
      end else if (init_en || pot_wr_en) wr_collision <= 1'b1;
      case (state)
        IDLE: if (decay_start) begin
          state <= FETCH;
          idx <= '0;
          busy <= 1'b1;
          wr_collision <= 1'b0;
        end
        FETCH: begin
          out_valid <= 1'b1;
          out_addr <= idx;
          out_potential <= dec;
          state <= APPLY;
        end
        APPLY: if (out_ready) begin
          out_valid <= 1'b0;
          pot[idx] <= out_potential;
          if (idx == ADDR_W'(NUM_NEURONS - 1)) begin
            state <= FIN;
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_potential_decay_array.sv
// tb_potential_decay_array: randomized and directed checks of the decay scan against
// a field-level arithmetic model of the FP32 decay rules.
module tb_potential_decay_array;
  localparam int N = 32;
  localparam int AW = 5;
  localparam logic [31:0] IP = 32'h41DED852;
  localparam logic [31:0] RIN [9] = '{32'h41DED852, 32'h41DED852, 32'h41DED852, 32'h3F800000,
    32'h41DED852, 32'h00800000, 32'hC0000000, 32'h7F800000, 32'h80000000};
  localparam logic [3:0] RRT [9] = '{4'b0100, 4'b1000, 4'b0011, 4'b0011, 4'b0001,
    4'b0010, 4'b0100, 4'b1000, 4'b0011};
  localparam logic [31:0] REXP [9] = '{32'h40DED852, 32'h405ED852, 32'h41A7223D, 32'h3F400000,
    32'h41DED852, 32'h00000000, 32'hBF000000, 32'h7F800000, 32'h80000000};
  localparam logic [3:0] RTAB [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b0000, 4'b0110};

  logic CLK = 1'b0, RESET = 1'b1;
  logic init_en = 0, pot_wr_en = 0, decay_start = 0, out_ready = 1;
  logic [AW-1:0] init_addr = '0, pot_wr_addr = '0;
  logic [3:0] init_rate = '0;
  logic [31:0] init_potential = '0, pot_wr_data = '0;
  logic busy, out_valid, done, wr_collision;
  logic [AW-1:0] out_addr;
  logic [31:0] out_potential;

  potential_decay_array dut (
    .CLK(CLK), .RESET(RESET), .init_en(init_en), .init_addr(init_addr), .init_rate(init_rate),
    .init_potential(init_potential), .pot_wr_en(pot_wr_en), .pot_wr_addr(pot_wr_addr),
    .pot_wr_data(pot_wr_data), .decay_start(decay_start), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_potential(out_potential), .done(done),
    .wr_collision(wr_collision));

  always #5 CLK = ~CLK;

  int tests = 0, fails = 0;
  logic [31:0] mpot [N];
  logic [3:0] mrate [N];
  logic [31:0] got_pot [N];
  logic [AW-1:0] got_addr [N];
  int got_n, done_at;
  logic col_after;

  // Value = sig * 2^(e-150); scale the significand, renormalise, then subtract the divide power.
  function automatic logic [31:0] ref_decay(logic [31:0] x, logic [3:0] r);
    int e = int'(x[30:23]);
    longint sig = longint'({1'b1, x[22:0]});
    int mul, k;
    if (e == 255) return x;
    if (e == 0) return {x[31], 31'b0};
    case (r)
      4'b0010: begin mul = 1; k = 1; end
      4'b0100: begin mul = 1; k = 2; end
      4'b1000: begin mul = 1; k = 3; end
      4'b0011: begin mul = 3; k = 2; end
      default: return x;
    endcase
    sig = sig * mul;
    while (sig >= (64'd1 << 24)) begin sig = sig >> 1; e++; end
    e = e - k;
    if (e <= 0) return {x[31], 31'b0};
    return {x[31], e[7:0], sig[22:0]};
  endfunction

  function automatic logic [31:0] rand_pot();
    int k = $urandom_range(0, 7);
    logic [7:0] e = k == 0 ? 8'd0 : k == 1 ? 8'd1 : k == 2 ? 8'd2 : k == 3 ? 8'd255 :
                    k == 4 ? 8'd3 : 8'($urandom_range(0, 255));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin mpot[i] = IP; mrate[i] = 4'b0001; end
  endtask

  task automatic model_scan();
    for (int i = 0; i < N; i++) mpot[i] = ref_decay(mpot[i], mrate[i]);
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic do_init(input int a, input logic [3:0] rt, input logic [31:0] p);
    init_en = 1; init_addr = a[AW-1:0]; init_rate = rt; init_potential = p;
    tick();
    init_en = 0;
    mrate[a] = rt; mpot[a] = p;
  endtask

  task automatic wait_done(inout int c);
    while (!done && c < 20 * N) begin tick(); c++; end
  endtask

  task automatic run_scan(input bit rnd);
    int c = 1;
    got_n = 0; done_at = -1;
    decay_start = 1;
    tick();
    decay_start = 0; init_en = 0; pot_wr_en = 0;
    col_after = wr_collision;
    while (done_at < 0 && c <= 20 * N) begin
      if (done) done_at = c;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready && got_n < N) begin
        got_pot[got_n] = out_potential; got_addr[got_n] = out_addr; got_n++;
      end
      tick(); c++;
    end
    out_ready = 1;
    tick();
  endtask

  task automatic test_reset();
    RESET = 1; tick(); tick();
    tests++;
    if ({busy, out_valid, done, wr_collision, out_addr, out_potential} !== '0) begin
      fails++; $display("FAIL reset_outputs got %b/%b/%b/%b/%h/%h want all zero",
        busy, out_valid, done, wr_collision, out_addr, out_potential);
    end
    RESET = 0; tick();
    model_reset();
    run_scan(0);
    model_scan();
    tests++;
    if (done_at !== 2 * N + 1) begin fails++; $display("FAIL reset_scan_done got %0d want %0d", done_at, 2 * N + 1); end
    for (int i = 0; i < N; i++) begin
      tests++;
      if (got_addr[i] !== i[AW-1:0] || got_pot[i] !== IP) begin
        fails++; $display("FAIL reset_scan[%0d] got %h/%h want %h/%h", i, got_addr[i], got_pot[i], i[AW-1:0], IP);
      end
    end
  endtask

  task automatic test_half_all();
    for (int i = 0; i < N; i++) do_init(i, 4'b0010, IP);
    run_scan(0);
    model_scan();
    tests++;
    if (done_at !== 2 * N + 1) begin fails++; $display("FAIL half_done got %0d want %0d", done_at, 2 * N + 1); end
    tests++;
    if (got_n !== N) begin fails++; $display("FAIL half_count got %0d want %0d", got_n, N); end
    for (int i = 0; i < N; i++) begin
      tests++;
      if (got_addr[i] !== i[AW-1:0] || got_pot[i] !== 32'h415ED852) begin
        fails++; $display("FAIL half[%0d] got %h/%h want %h/415ed852", i, got_addr[i], got_pot[i], i[AW-1:0]);
      end
    end
  endtask

  task automatic test_rates();
    for (int i = 0; i < 9; i++) do_init(i, RRT[i], RIN[i]);
    run_scan(0);
    model_scan();
    for (int i = 0; i < 9; i++) begin
      tests++;
      if (got_pot[i] !== REXP[i]) begin fails++; $display("FAIL rate_const[%0d] got %h want %h", i, got_pot[i], REXP[i]); end
    end
    for (int i = 9; i < N; i++) begin
      tests++;
      if (got_pot[i] !== mpot[i]) begin fails++; $display("FAIL rate_model[%0d] got %h want %h", i, got_pot[i], mpot[i]); end
    end
  endtask

  task automatic test_stall();
    int c = 1;
    logic [31:0] sp;
    logic [AW-1:0] sa;
    logic found = 0;
    for (int i = 0; i < N; i++) do_init(i, 4'b0010, IP);
    decay_start = 1; tick(); decay_start = 0;
    while (!found && c < 20 * N) begin
      if (out_valid && out_addr == 3) begin found = 1; out_ready = 0; end
      else begin tick(); c++; end
    end
    sp = out_potential; sa = out_addr;
    tests++;
    if (!found || sp !== 32'h415ED852) begin fails++; $display("FAIL stall_value found=%0b got %h want 415ed852", found, sp); end
    for (int k = 0; k < 5; k++) begin
      tick(); c++;
      tests++;
      if (out_valid !== 1'b1 || out_addr !== sa || out_potential !== sp) begin
        fails++; $display("FAIL stall_hold[%0d] got %b/%h/%h want 1/%h/%h", k, out_valid, out_addr, out_potential, sa, sp);
      end
    end
    out_ready = 1;
    wait_done(c);
    tests++;
    if (c !== 2 * N + 6) begin fails++; $display("FAIL stall_done got %0d want %0d", c, 2 * N + 6); end
    tick();
    model_scan();
    run_scan(0);
    model_scan();
    for (int i = 0; i < N; i++) begin
      tests++;
      if (got_pot[i] !== 32'h40DED852 || got_pot[i] !== mpot[i]) begin
        fails++; $display("FAIL stall_second[%0d] got %h want 40ded852", i, got_pot[i]);
      end
    end
  endtask

  task automatic test_collision();
    int c = 1;
    decay_start = 1; tick(); decay_start = 0;
    repeat (3) begin tick(); c++; end
    pot_wr_en = 1; pot_wr_addr = 2; pot_wr_data = 32'h12345678; decay_start = 1;
    tick(); c++;
    pot_wr_en = 0; decay_start = 0;
    tests++;
    if (wr_collision !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL coll_flag got %b busy %b want 1/1", wr_collision, busy); end
    wait_done(c);
    tests++;
    if (c !== 2 * N + 1) begin fails++; $display("FAIL coll_done got %0d want %0d", c, 2 * N + 1); end
    tick(); tick();
    tests++;
    if (wr_collision !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL coll_sticky got %b/%b/%b want 1/0/0", wr_collision, busy, done);
    end
    model_scan();
    run_scan(0);
    model_scan();
    tests++;
    if (col_after !== 1'b0) begin fails++; $display("FAIL coll_clear got %b want 0", col_after); end
    for (int i = 0; i < N; i++) begin
      tests++;
      if (got_pot[i] !== mpot[i]) begin fails++; $display("FAIL coll_scan[%0d] got %h want %h", i, got_pot[i], mpot[i]); end
    end
  endtask

  task automatic test_reset_mid_scan();
    int c = 0;
    logic seen = 0;
    decay_start = 1; tick(); decay_start = 0;
    while (!(out_valid && out_addr == 7) && c < 20 * N) begin tick(); c++; end
    tests++;
    if (!(out_valid && out_addr == 7)) begin fails++; $display("FAIL midrst_reach got %h want 07", out_addr); end
    RESET = 1; #1;
    tests++;
    if ({busy, out_valid, done, wr_collision, out_addr, out_potential} !== '0) begin
      fails++; $display("FAIL midrst_outputs got %b/%b/%b/%b/%h/%h want all zero",
        busy, out_valid, done, wr_collision, out_addr, out_potential);
    end
    tick();
    RESET = 0;
    model_reset();
    repeat (4) begin tick(); seen = seen | done | busy; end
    tests++;
    if (seen !== 1'b0) begin fails++; $display("FAIL midrst_nodone got %b want 0", seen); end
    run_scan(0);
    model_scan();
    tests++;
    if (done_at !== 2 * N + 1) begin fails++; $display("FAIL midrst_done got %0d want %0d", done_at, 2 * N + 1); end
    for (int i = 0; i < N; i++) begin
      tests++;
      if (got_pot[i] !== IP) begin fails++; $display("FAIL midrst_scan[%0d] got %h want %h", i, got_pot[i], IP); end
    end
  endtask

  task automatic test_random();
    for (int round = 0; round < 3; round++) begin
      int a;
      logic [31:0] p1, p2;
      logic [3:0] rt;
      repeat (40) begin
        a = $urandom_range(0, N - 1);
        rt = $urandom_range(0, 3) == 0 ? 4'($urandom) : RTAB[$urandom_range(0, 6)];
        if ($urandom_range(0, 1) == 1) do_init(a, rt, rand_pot());
        else begin
          p1 = rand_pot();
          pot_wr_en = 1; pot_wr_addr = a[AW-1:0]; pot_wr_data = p1;
          tick();
          pot_wr_en = 0; mpot[a] = p1;
        end
      end
      a = $urandom_range(0, N - 1);
      p1 = rand_pot(); p2 = rand_pot(); rt = RTAB[$urandom_range(0, 6)];
      init_en = 1; init_addr = a[AW-1:0]; init_rate = rt; init_potential = p1;
      pot_wr_en = 1; pot_wr_addr = a[AW-1:0]; pot_wr_data = p2;
      tick();
      init_en = 0; pot_wr_en = 0;
      mpot[a] = p1; mrate[a] = rt;
      a = $urandom_range(0, N - 1);
      p2 = rand_pot();
      pot_wr_en = 1; pot_wr_addr = a[AW-1:0]; pot_wr_data = p2;
      mpot[a] = p2;
      run_scan(1);
      model_scan();
      tests++;
      if (got_n !== N || done_at < 2 * N + 1) begin
        fails++; $display("FAIL rand_count[%0d] got %0d done %0d want %0d", round, got_n, done_at, N);
      end
      for (int i = 0; i < N; i++) begin
        tests++;
        if (got_addr[i] !== i[AW-1:0] || got_pot[i] !== mpot[i]) begin
          fails++; $display("FAIL rand[%0d][%0d] got %h/%h want %h/%h", round, i, got_addr[i], got_pot[i], i[AW-1:0], mpot[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_half_all();
    test_rates();
    test_stall();
    test_collision();
    test_reset_mid_scan();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
